ksa32_arbiter: RTL and testbench



---
 rtl/ksa32_arb_pkg.sv | 26 ++
 rtl/ksa32.sv | 41 ++++
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/ksa32_arbiter.sv | 143 ++++++++++++++
 tb/tb_ksa32_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ksa32_arb_pkg.sv
// ksa32_arb_pkg: shared definitions for the shared-adder arbiter.
//   DATA_W    - operand/result width of the shared adder.
//   MAX_ID_W  - widest requester index the result record can carry (16 ports).
//   res_rec_t - packed result record {sum, cout, id}.
//   clog2_f   - ceil(log2(n)), used to validate ID_W against NUM_REQ.
package ksa32_arb_pkg;

  localparam int DATA_W   = 32;
  localparam int MAX_ID_W = 4;

  typedef struct packed {
    logic [DATA_W-1:0]   sum;
    logic                cout;
    logic [MAX_ID_W-1:0] id;
  } res_rec_t;

  function automatic int clog2_f(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ksa32.sv
// ksa32: 32-bit Kogge-Stone parallel-prefix adder, purely combinational.
// Ports:
//   a, b  in  32  operands
//   cin   in  1   carry-in
//   sum   out 32  (a + b + cin) mod 2^32
//   cout  out 1   carry out of bit 31
module ksa32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] p0;
  logic [31:0] g_fin;

  assign p0 = a ^ b;

  // Level 0 folds cin into bit 0's generate, so each prefix G[i] is the
  // carry out of bit i including the carry-in. Levels 1..4 combine spans of
  // 1, 2, 4, 8; the final span-16 step is done below without a propagate.
  for (genvar gi = 0; gi < 5; gi++) begin : g_lvl
    logic [31:0] g;
    logic [31:0] p;
    if (gi == 0) begin : g_init
      assign g = (a & b) | {31'b0, p0[0] & cin};
      assign p = p0;
    end else begin : g_step
      localparam int D = 1 << (gi - 1);
      assign g = g_lvl[gi-1].g | (g_lvl[gi-1].p & (g_lvl[gi-1].g << D));
      assign p = g_lvl[gi-1].p & (g_lvl[gi-1].p << D);
    end
  end

  assign g_fin = g_lvl[4].g | (g_lvl[4].p & (g_lvl[4].g << 16));

  assign sum  = p0 ^ {g_fin[30:0], cin};
  assign cout = g_fin[31];

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant generator with rotating priority pointer.
// Ports:
//   clk, rst  in              clock, synchronous active-high reset
//   en        in   1          grants allowed this cycle (slot free, not in reset)
//   req       in   NUM_REQ    request vector
//   grant     out  NUM_REQ    one-hot or zero grant (combinational)
//   grant_id  out  ID_W       index of the winning request (valid when |req)
// The pointer moves to winner+1 only when a grant is actually issued.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0]      rr_ptr_reg;
  logic [ID_W-1:0]      rr_ptr_next;
  logic [2*NUM_REQ-1:0] rot_dbl;
  logic [2*NUM_REQ-1:0] gnt_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   gnt_rot;
  logic [NUM_REQ-1:0]   gnt_raw;
  logic                 unused_dbl_bits;

  // Rotate so that index rr_ptr sits at bit 0, take the lowest set bit, then
  // rotate back. Doubling the vector turns the modulo wrap into a plain shift.
  assign rot_dbl = {req, req} >> rr_ptr_reg;
  assign req_rot = rot_dbl[NUM_REQ-1:0];
  assign gnt_rot = req_rot & ~(req_rot - NUM_REQ'(1));
  assign gnt_dbl = {gnt_rot, gnt_rot} << rr_ptr_reg;
  assign gnt_raw = gnt_dbl[2*NUM_REQ-1:NUM_REQ];

  assign unused_dbl_bits = ^{rot_dbl[2*NUM_REQ-1:NUM_REQ], gnt_dbl[NUM_REQ-1:0]};

  assign grant = en ? gnt_raw : '0;

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_raw[i]) grant_id = ID_W'(i);
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (|grant) begin
      rr_ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_reg <= '0;
    else     rr_ptr_reg <= rr_ptr_next;
  end

endmodule

// File: rtl/ksa32_arbiter.sv
// ksa32_arbiter: shares one ksa32 adder among NUM_REQ requesters.
// Round-robin picks one request per cycle; the sum is captured in a single
// result slot with a valid/ready handshake (one result per cycle while
// res_ready is high, simultaneous drain+accept keeps res_valid asserted).
// Ports:
//   clk, rst   in            clock, synchronous active-high reset
//   req_valid  in  NUM_REQ   per-requester request
//   req_ready  out NUM_REQ   per-requester grant, one-hot or zero
//   req_a/b    in  NUM_REQ*32 operands, requester i at [32i+31:32i]
//   req_cin    in  NUM_REQ   per-requester carry-in
//   res_valid  out 1         result slot full
//   res_ready  in  1         consumer takes the result
//   res_sum    out 32        registered sum
//   res_cout   out 1         registered carry-out
//   res_id     out ID_W      requester that produced the result
//   res_ovf    out 1         signed overflow, only when KSA32_ARB_OVF_EN is defined
module ksa32_arbiter
  import ksa32_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_cin,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_sum,
  output logic                      res_cout,
`ifdef KSA32_ARB_OVF_EN
  output logic                      res_ovf,
`endif
  output logic [ID_W-1:0]           res_id
);

  if (ID_W != clog2_f(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_cfg
    $error("ksa32_arbiter: NUM_REQ must be 2..16 and ID_W must equal clog2(NUM_REQ)");
  end

  logic                           slot_free;
  logic                           transfer;
  logic [ID_W-1:0]                win_id;
  logic [NUM_REQ-1:0][DATA_W-1:0] a_term;
  logic [NUM_REQ-1:0][DATA_W-1:0] b_term;
  logic [DATA_W-1:0]              a_sel;
  logic [DATA_W-1:0]              b_sel;
  logic                           cin_sel;
  logic [DATA_W-1:0]              sum_w;
  logic                           cout_w;
  res_rec_t                       res_reg;
  res_rec_t                       res_next;
  logic                           res_valid_reg;
  logic                           unused_id_bits;

  // The slot can take a new result if empty or being drained this edge.
  assign slot_free = !res_valid_reg | res_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (slot_free & ~rst),
    .req      (req_valid),
    .grant    (req_ready),
    .grant_id (win_id)
  );

  assign transfer = |req_ready;

  // One-hot AND-OR operand mux driven by the (gated) grant.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mux
    assign a_term[gi] = {DATA_W{req_ready[gi]}} & req_a[gi*DATA_W +: DATA_W];
    assign b_term[gi] = {DATA_W{req_ready[gi]}} & req_b[gi*DATA_W +: DATA_W];
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_sel = a_sel | a_term[i];
      b_sel = b_sel | b_term[i];
    end
  end

  assign cin_sel = |(req_ready & req_cin);

  ksa32 u_add (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (cin_sel),
    .sum  (sum_w),
    .cout (cout_w)
  );

  always_comb begin
    res_next      = '0;
    res_next.sum  = sum_w;
    res_next.cout = cout_w;
    res_next.id   = MAX_ID_W'(win_id);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_reg       <= '0;
      res_valid_reg <= 1'b0;
    end else if (transfer) begin
      res_reg       <= res_next;
      res_valid_reg <= 1'b1;
    end else if (res_ready) begin
      // Drain only; data registers keep their last value.
      res_valid_reg <= 1'b0;
    end
  end

`ifdef KSA32_ARB_OVF_EN
  logic ovf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (transfer) begin
      ovf_reg <= (a_sel[DATA_W-1] == b_sel[DATA_W-1]) & (sum_w[DATA_W-1] != a_sel[DATA_W-1]);
    end
  end

  assign res_ovf = ovf_reg;
`endif

  // The record carries room for 16 requesters; narrower configs ignore the top bits.
  assign unused_id_bits = ^res_reg.id;

  assign res_valid = res_valid_reg;
  assign res_sum   = res_reg.sum;
  assign res_cout  = res_reg.cout;
  assign res_id    = res_reg.id[ID_W-1:0];

endmodule

// File: tb/tb_ksa32_arbiter.sv
module tb_ksa32_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]    req_cin;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_sum;
  logic            res_cout;
  logic [1:0]      res_id;
`ifdef KSA32_ARB_OVF_EN
  logic            res_ovf;
`endif

  always #5 clk = ~clk;

  ksa32_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
`ifdef KSA32_ARB_OVF_EN
    .res_ovf   (res_ovf),
`endif
    .res_id    (res_id)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: contents of the result slot and the scan start.
  logic        m_valid;
  logic [31:0] m_sum;
  logic        m_cout;
  logic        m_ovf;
  int          m_id;
  int          m_ptr;
  logic [N-1:0] last_grant;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int m_winner();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(3, 0))
      0:       return 32'hFFFF_FFFF;
      1:       return ($urandom_range(1, 0) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_cin[i]        = cin;
  endtask

  // Called #1 after a rising edge with inputs already driven: checks the
  // combinational grant, advances the model by one edge, checks the slot.
  task automatic cycle();
    int          w;
    logic [N-1:0] exp_ready;
    logic [32:0] full;
    logic [31:0] a;
    logic [31:0] b;
    #2;
    w = m_winner();
    exp_ready = '0;
    if (!rst && w >= 0 && (!m_valid || res_ready)) exp_ready[w] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    last_grant = exp_ready;
    if (rst) begin
      m_valid = 0; m_sum = 0; m_cout = 0; m_ovf = 0; m_id = 0; m_ptr = 0;
    end else if (exp_ready != 0) begin
      a       = req_a[w*32 +: 32];
      b       = req_b[w*32 +: 32];
      full    = {1'b0, a} + {1'b0, b} + {32'b0, req_cin[w]};
      m_sum   = full[31:0];
      m_cout  = full[32];
      m_ovf   = (a[31] == b[31]) && (m_sum[31] != a[31]);
      m_id    = w;
      m_valid = 1;
      m_ptr   = (w + 1) % N;
    end else if (m_valid && res_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("res_valid", res_valid, m_valid);
    chk("res_sum", res_sum, m_sum);
    chk("res_cout", res_cout, m_cout);
    chk("res_id", res_id, m_id);
`ifdef KSA32_ARB_OVF_EN
    chk("res_ovf", res_ovf, m_ovf);
`endif
  endtask

  initial begin
    vecs[0] = '{0, 32'h158A9382, 32'h70959157, 1'b0, 32'h862024D9, 1'b0, 1'b1};
    vecs[1] = '{1, 32'h9A4E6483, 32'hC6BD64D1, 1'b1, 32'h610BC955, 1'b1, 1'b1};
    vecs[2] = '{2, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[3] = '{3, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[4] = '{0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[5] = '{1, 32'h12345678, 32'h0EDCBA98, 1'b1, 32'h21111111, 1'b0, 1'b0};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; res_ready = 1'b1;
    m_valid = 0; m_sum = 0; m_cout = 0; m_ovf = 0; m_id = 0; m_ptr = 0;
    @(posedge clk); #1;
    req_valid = 4'b1111;          // requests present during reset must not be granted
    cycle();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_res_id", res_id, 0);
    req_valid = '0;
    cycle();
    rst = 1'b0;

    // Single-requester vectors with known sums.
    for (int t = 0; t < 6; t++) begin
      req_valid = '0;
      req_valid[vecs[t].idx] = 1'b1;
      set_req(vecs[t].idx, vecs[t].a, vecs[t].b, vecs[t].cin);
      #1;
      chk("tbl_ready", req_ready, 1 << vecs[t].idx);
      cycle();
      chk("tbl_valid", res_valid, 1);
      chk("tbl_sum", res_sum, vecs[t].sum);
      chk("tbl_cout", res_cout, vecs[t].cout);
      chk("tbl_id", res_id, vecs[t].idx);
`ifdef KSA32_ARB_OVF_EN
      chk("tbl_ovf", res_ovf, vecs[t].ovf);
`endif
      req_valid = '0;
    end

    // All four valid continuously from reset: grants rotate 0,1,2,3,0.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 32'h1111_1111 * (i + 1), 32'h10 + i, 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", req_ready, 1 << (k % 4));
      cycle();
      chk("rr_valid", res_valid, 1);
      chk("rr_id", res_id, k % 4);
    end
    req_valid = '0;
    cycle();

    // Backpressure: result held, req3 waiting, then swap on res_ready.
    res_ready = 1'b0;
    req_valid = 4'b0001;
    set_req(0, 32'd1, 32'd2, 1'b0);
    cycle();
    req_valid = 4'b1000;
    set_req(3, 32'd10, 32'd20, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", req_ready, 0);
      cycle();
      chk("bp_valid", res_valid, 1);
      chk("bp_sum", res_sum, 3);
      chk("bp_id", res_id, 0);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_accept", req_ready, 4'b1000);
    cycle();
    chk("swap_valid", res_valid, 1);
    chk("swap_sum", res_sum, 30);
    chk("swap_id", res_id, 3);
    req_valid = '0;
    cycle();

    // Reset while a result is held and requests pend; pointer returns to 0.
    res_ready = 1'b0;
    req_valid = 4'b0010;
    set_req(1, 32'd5, 32'd6, 1'b0);
    cycle();
    req_valid = 4'b0110;
    set_req(2, 32'd7, 32'd8, 1'b1);
    cycle();
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", req_ready, 0);
    cycle();
    rst = 1'b0;
    chk("post_rst_valid", res_valid, 0);
    chk("post_rst_sum", res_sum, 0);
    #1;
    chk("post_rst_grant", req_ready, 4'b0010);
    cycle();
    chk("post_rst_id", res_id, 1);
    res_ready = 1'b1;
    req_valid = '0;
    cycle();

    // Random traffic against the model, obeying the hold-until-granted rule.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(1, 0) != 0) begin
          req_valid[i] = 1'b1;
          set_req(i, rand_op(), rand_op(), 1'($urandom_range(1, 0)));
        end
      end
      res_ready = ($urandom_range(9, 0) < 7);
      rst       = ($urandom_range(99, 0) == 0);
      cycle();
      for (int i = 0; i < N; i++) begin
        if (last_grant[i]) begin
          if ($urandom_range(1, 0) != 0) req_valid[i] = 1'b0;
          else set_req(i, rand_op(), rand_op(), 1'($urandom_range(1, 0)));
        end
      end
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
